obj_row_sequencer: RTL

- Per-scanline OBJ fetch controller. Takes one sprite's attributes and walks every pixel of that sprite's row on the current scanline.
- For each pixel it drives the sprite-local coordinate through the OBJ flip datapath. It then issues one OBJ-VRAM byte-address request per visible pixel over a valid/ready handshake.
- Sits between the OBJ attribute scanner (upstream, start/busy) and the OBJ VRAM read port (downstream).

---
 rtl/obj_pkg.sv | 28 ++
 rtl/obj_row_sequencer_if.sv | 26 ++
 rtl/obj_flip_unit.sv | 22 ++
 rtl/obj_row_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared types and constants for the OBJ row fetch path.
package obj_pkg;

    localparam int unsigned SCREEN_W_DEF     = 240;
    localparam int unsigned VRAM_AW_DEF      = 15;
    localparam int unsigned OBJ_TILE_BYTES   = 32;
    localparam int unsigned OBJ_2D_ROW_TILES = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } obj_seq_state_t;

    // Sprite attributes captured at start for the whole row walk
    typedef struct packed {
        logic [8:0] obj_x;
        logic [7:0] hsize;
        logic [7:0] vsize;
        logic       hflip;
        logic       vflip;
        logic [9:0] tile_base;
        logic       bpp8;
        logic       map_1d;
    } obj_attr_t;

endpackage

// File: rtl/obj_row_sequencer_if.sv
// OBJ VRAM byte-address request channel (valid/ready).
interface obj_row_sequencer_if #(
    parameter int unsigned VRAM_AW = 15
);
    logic               req_valid;
    logic               req_ready;
    logic [VRAM_AW-1:0] req_addr;
    logic               req_nib;
    logic [7:0]         req_sx;

    modport master (
        output req_valid,
        output req_addr,
        output req_nib,
        output req_sx,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_nib,
        input  req_sx,
        output req_ready
    );
endinterface

// File: rtl/obj_flip_unit.sv
// Maps sprite-local pixel coordinates through horizontal/vertical flip.
module obj_flip_unit (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic [7:0] hsize,
    input  logic [7:0] vsize,
    input  logic       hflip,
    input  logic       vflip,
    output logic [5:0] fx_c,
    output logic [5:0] fy_c
);
    logic [5:0] x_max_c;
    logic [5:0] y_max_c;

    // 64-pixel sprites wrap to 63 in the 6-bit domain, which is the intended maximum
    always_comb begin
        x_max_c = 6'(hsize - 8'd1);
        y_max_c = 6'(vsize - 8'd1);
        fx_c    = hflip ? (x_max_c - x) : x;
        fy_c    = vflip ? (y_max_c - y) : y;
    end
endmodule

// File: rtl/obj_row_sequencer.sv
// Walks one sprite's row on the current scanline and issues one VRAM byte request per visible pixel.
module obj_row_sequencer
    import obj_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned VRAM_AW  = VRAM_AW_DEF
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          scanline,
    input  logic [8:0]          obj_x,
    input  logic [7:0]          obj_y,
    input  logic [7:0]          hsize,
    input  logic [7:0]          vsize,
    input  logic                hflip,
    input  logic                vflip,
    input  logic [9:0]          tile_base,
    input  logic                bpp8,
    input  logic                map_1d,
    obj_row_sequencer_if.master req,
    output logic                busy,
    output logic                done
);
    localparam int unsigned AW = VRAM_AW + 1;

    obj_seq_state_t     state_q, state_d;
    obj_attr_t          attr_q, attr_d;
    logic [7:0]         dy_q, dy_d;
    logic [6:0]         px_q, px_d;
    logic               last_q, last_d;
    logic               req_valid_d;
    logic [VRAM_AW-1:0] req_addr_d;
    logic               req_nib_d;
    logic [7:0]         req_sx_d;
    logic               busy_d;
    logic               done_d;

    logic [5:0]         fx_c, fy_c;
    logic [8:0]         sx_c;
    logic               visible_c;
    logic [AW-1:0]      stride_c, tile_c, addr_c;

    obj_flip_unit u_flip (
        .x     (px_q[5:0]),
        .y     (dy_q[5:0]),
        .hsize (attr_q.hsize),
        .vsize (attr_q.vsize),
        .hflip (attr_q.hflip),
        .vflip (attr_q.vflip),
        .fx_c  (fx_c),
        .fy_c  (fy_c)
    );

    // Screen position and byte address of the pixel currently selected by px
    always_comb begin
        sx_c      = attr_q.obj_x + 9'(px_q);
        visible_c = 32'(sx_c) < SCREEN_W;
        stride_c  = attr_q.map_1d ? (AW'(attr_q.hsize >> 3) << attr_q.bpp8)
                                  : AW'(OBJ_2D_ROW_TILES);
        tile_c    = AW'(attr_q.tile_base) + AW'(fy_c[5:3]) * stride_c
                  + (AW'(fx_c[5:3]) << attr_q.bpp8);
        addr_c    = tile_c * AW'(OBJ_TILE_BYTES)
                  + (attr_q.bpp8 ? AW'({fy_c[2:0], fx_c[2:0]})
                                 : AW'({fy_c[2:0], fx_c[2:1]}));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        attr_d      = attr_q;
        dy_d        = dy_q;
        px_d        = px_q;
        last_d      = last_q;
        req_valid_d = req.req_valid;
        req_addr_d  = req.req_addr;
        req_nib_d   = req.req_nib;
        req_sx_d    = req.req_sx;

        if (abort) begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        attr_d.obj_x     = obj_x;
                        attr_d.hsize     = hsize;
                        attr_d.vsize     = vsize;
                        attr_d.hflip     = hflip;
                        attr_d.vflip     = vflip;
                        attr_d.tile_base = tile_base;
                        attr_d.bpp8      = bpp8;
                        attr_d.map_1d    = map_1d;
                        dy_d             = scanline - obj_y;
                        state_d          = CHECK;
                    end
                end
                CHECK: begin
                    if (dy_q >= attr_q.vsize) begin
                        state_d = DONE;
                    end else begin
                        px_d    = 7'd0;
                        last_d  = 1'b0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // A new pixel is selected only when the output slot is free or draining
                    if (!req.req_valid || req.req_ready) begin
                        req_valid_d = 1'b0;
                        if (last_q) begin
                            state_d = DONE;
                        end else begin
                            if (visible_c) begin
                                req_valid_d = 1'b1;
                                req_addr_d  = addr_c[VRAM_AW-1:0];
                                req_nib_d   = attr_q.bpp8 ? 1'b0 : fx_c[0];
                                req_sx_d    = sx_c[7:0];
                            end
                            if ({1'b0, px_q} == attr_q.hsize - 8'd1) begin
                                last_d = 1'b1;
                            end else begin
                                px_d = px_q + 7'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    req_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: begin
                    req_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end

        busy_d = (state_d == CHECK) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            attr_q        <= '0;
            dy_q          <= 8'd0;
            px_q          <= 7'd0;
            last_q        <= 1'b0;
            req.req_valid <= 1'b0;
            req.req_addr  <= '0;
            req.req_nib   <= 1'b0;
            req.req_sx    <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            attr_q        <= attr_d;
            dy_q          <= dy_d;
            px_q          <= px_d;
            last_q        <= last_d;
            req.req_valid <= req_valid_d;
            req.req_addr  <= req_addr_d;
            req.req_nib   <= req_nib_d;
            req.req_sx    <= req_sx_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end
endmodule
